// File: rtl/axi_spy_pkg.sv
// Shared constants and types for the AXI spy FIFO drain controller.
package axi_spy_pkg;

    localparam int NUM_SPY_CH = 4;

    localparam logic [1:0] CH_AR = 2'd0;
    localparam logic [1:0] CH_AW = 2'd1;
    localparam logic [1:0] CH_W  = 2'd2;
    localparam logic [1:0] CH_R  = 2'd3;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } spy_state_e;

endpackage

// File: rtl/axi_spy_drain_ctrl_if.sv
// Readout stream carrying popped spy entries tagged with channel and timestamp.
interface axi_spy_drain_ctrl_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 16
) ();
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic [1:0]            m_ch_o;
    logic [TS_WIDTH-1:0]   m_ts_o;

    modport master (
        output m_valid_o,
        output m_data_o,
        output m_ch_o,
        output m_ts_o,
        input  m_ready_i
    );

    modport slave (
        input  m_valid_o,
        input  m_data_o,
        input  m_ch_o,
        input  m_ts_o,
        output m_ready_i
    );
endinterface

// File: rtl/axi_spy_drain_ctrl_rr_arbiter.sv
// Combinational 4-way round-robin picker; search starts one past last_grant.
module spy_rr_arbiter
    import axi_spy_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last_grant,
    output logic [3:0] gnt_onehot,
    output logic [1:0] gnt_idx,
    output logic       any_gnt
);

    logic [7:0] rot8_s;
    logic [3:0] rot_s;
    logic [1:0] off_s;

    // Rotate requests so bit 0 is the highest-priority channel, then priority-encode.
    always_comb begin
        rot8_s  = {req, req} >> (3'({1'b0, last_grant}) + 3'd1);
        rot_s   = rot8_s[3:0];
        off_s   = 2'd0;
        any_gnt = 1'b1;
        casez (rot_s)
            4'b???1: off_s = 2'd0;
            4'b??10: off_s = 2'd1;
            4'b?100: off_s = 2'd2;
            4'b1000: off_s = 2'd3;
            default: begin
                off_s   = 2'd0;
                any_gnt = 1'b0;
            end
        endcase
        gnt_idx = last_grant + 2'd1 + off_s;
        if (any_gnt) begin
            gnt_onehot = 4'b0001 << gnt_idx;
        end else begin
            gnt_onehot = 4'b0000;
        end
    end

endmodule

// File: rtl/axi_spy_drain_ctrl.sv
// Drains the AR/AW/W/R spy FIFOs round-robin onto one valid/ready readout stream.
module axi_spy_drain_ctrl
    import axi_spy_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TS_WIDTH   = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_SPY_CH-1:0]          ch_empty_i,
    input  logic [NUM_SPY_CH*DATA_WIDTH-1:0] ch_data_i,
    input  logic [NUM_SPY_CH-1:0]          ch_en_i,
    input  logic                           drain_en_i,
    output logic [NUM_SPY_CH-1:0]          ch_pop_o,
    axi_spy_drain_ctrl_if.master           m_if,
    output logic [CNT_WIDTH-1:0]           beat_cnt_o,
    output logic                           busy_o
);

    spy_state_e            state_q, state_d;
    logic [1:0]            last_grant_q, last_grant_d;
    logic [TS_WIDTH-1:0]   ts_q, ts_d;
    logic [CNT_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [1:0]            ch_q, ch_d;
    logic [TS_WIDTH-1:0]   mts_q, mts_d;

    logic [3:0] elig_s;
    logic [3:0] gnt_onehot_s;
    logic [1:0] gnt_idx_s;
    logic       any_gnt_s;
    logic       hs_s;
    logic       load_s;

    spy_rr_arbiter u_arb (
        .req        (elig_s),
        .last_grant (last_grant_q),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any_gnt    (any_gnt_s)
    );

    // Eligibility, handshake/load decode and next-state computation.
    always_comb begin
        if (drain_en_i) begin
            elig_s = ch_en_i & ~ch_empty_i;
        end else begin
            elig_s = 4'b0000;
        end

        hs_s   = (state_q == ST_SEND) & m_if.m_ready_i;
        // Reset gating keeps the pop strobe quiet while the block is held in reset.
        load_s = ((state_q == ST_IDLE) | hs_s) & any_gnt_s & ~reset;

        if (load_s) begin
            ch_pop_o = gnt_onehot_s;
        end else begin
            ch_pop_o = 4'b0000;
        end

        state_d      = state_q;
        last_grant_d = last_grant_q;
        data_d       = data_q;
        ch_d         = ch_q;
        mts_d        = mts_q;
        ts_d         = ts_q + TS_WIDTH'(1);

        if (load_s) begin
            data_d       = ch_data_i[gnt_idx_s*DATA_WIDTH +: DATA_WIDTH];
            ch_d         = gnt_idx_s;
            mts_d        = ts_q;
            last_grant_d = gnt_idx_s;
            state_d      = ST_SEND;
        end else if (hs_s) begin
            state_d = ST_IDLE;
        end else begin
            state_d = state_q;
        end

        if (hs_s) begin
            beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
        end else begin
            beat_cnt_d = beat_cnt_q;
        end
    end

    // State, output beat register, timestamp and beat counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            last_grant_q <= CH_R;
            ts_q         <= '0;
            beat_cnt_q   <= '0;
            data_q       <= '0;
            ch_q         <= 2'd0;
            mts_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            ts_q         <= ts_d;
            beat_cnt_q   <= beat_cnt_d;
            data_q       <= data_d;
            ch_q         <= ch_d;
            mts_q        <= mts_d;
        end
    end

    assign m_if.m_valid_o = (state_q == ST_SEND);
    assign m_if.m_data_o  = data_q;
    assign m_if.m_ch_o    = ch_q;
    assign m_if.m_ts_o    = mts_q;
    assign busy_o         = (state_q == ST_SEND);
    assign beat_cnt_o     = beat_cnt_q;

endmodule

// File: tb/tb_axi_spy_drain_ctrl.sv
// Scoreboard bench for axi_spy_drain_ctrl, built with a 4-bit timestamp to exercise wrap.
module tb_axi_spy_drain_ctrl;

    localparam int DW = 32;
    localparam int TW = 4;
    localparam int CW = 16;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    ch;
        logic [TW-1:0] ts;
    } beat_t;

    logic          clk;
    logic          reset;
    logic [3:0]    ch_empty;
    logic [4*DW-1:0] ch_data;
    logic [3:0]    ch_en;
    logic          drain_en;
    logic [3:0]    ch_pop;
    logic [CW-1:0] beat_cnt;
    logic          busy;

    axi_spy_drain_ctrl_if #(.DATA_WIDTH(DW), .TS_WIDTH(TW)) rd_if ();

    axi_spy_drain_ctrl #(.DATA_WIDTH(DW), .TS_WIDTH(TW), .CNT_WIDTH(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .ch_empty_i (ch_empty),
        .ch_data_i  (ch_data),
        .ch_en_i    (ch_en),
        .drain_en_i (drain_en),
        .ch_pop_o   (ch_pop),
        .m_if       (rd_if),
        .beat_cnt_o (beat_cnt),
        .busy_o     (busy)
    );

    int         total;
    int         bad;
    beat_t      sb[$];
    bit         mdl_send;
    logic [1:0] mdl_last;
    logic [TW-1:0] mdl_ts;
    int         mdl_cnt;
    logic [3:0] last_pop;
    logic [TW-1:0] last_hs_ts;
    logic [TW-1:0] prev_hs_ts;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_data();
        for (int k = 0; k < 4; k++) ch_data[k*DW +: DW] = $urandom;
    endtask

    // One clock: called at a falling edge with inputs already set; returns at the next falling edge.
    task automatic cycle();
        logic [3:0] elig;
        logic [3:0] exp_pop;
        logic       load;
        logic [1:0] g;
        beat_t      b;
        #1;
        elig = drain_en ? (ch_en & ~ch_empty) : 4'b0000;
        chk("valid", 64'(rd_if.m_valid_o), 64'(mdl_send));
        chk("busy", 64'(busy), 64'(mdl_send));
        chk("beat_cnt", 64'(beat_cnt), 64'(mdl_cnt));
        if (mdl_send && rd_if.m_ready_i) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 64'(sb.size()), 64'd1);
            end else begin
                b = sb.pop_front();
                chk("beat_data", 64'(rd_if.m_data_o), 64'(b.data));
                chk("beat_ch", 64'(rd_if.m_ch_o), 64'(b.ch));
                chk("beat_ts", 64'(rd_if.m_ts_o), 64'(b.ts));
                prev_hs_ts = last_hs_ts;
                last_hs_ts = rd_if.m_ts_o;
                mdl_cnt++;
            end
        end
        load    = (!mdl_send || rd_if.m_ready_i) && (elig != 4'b0000);
        exp_pop = 4'b0000;
        if (load) begin
            g = mdl_last;
            for (int i = 0; i < 4; i++) begin
                g = g + 2'd1;
                if (elig[g]) break;
            end
            exp_pop[g] = 1'b1;
            b.data = ch_data[g*DW +: DW];
            b.ch   = g;
            b.ts   = mdl_ts;
            sb.push_back(b);
            mdl_last = g;
            mdl_send = 1'b1;
        end else if (mdl_send && rd_if.m_ready_i) begin
            mdl_send = 1'b0;
        end
        chk("pop", 64'(ch_pop), 64'(exp_pop));
        last_pop = ch_pop;
        mdl_ts   = mdl_ts + 4'd1;
        @(negedge clk);
    endtask

    // Asynchronous reset between edges, immediate output check, release on a falling edge.
    task automatic do_reset();
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", 64'(rd_if.m_valid_o), 64'd0);
        chk("rst_data", 64'(rd_if.m_data_o), 64'd0);
        chk("rst_ch", 64'(rd_if.m_ch_o), 64'd0);
        chk("rst_ts", 64'(rd_if.m_ts_o), 64'd0);
        chk("rst_pop", 64'(ch_pop), 64'd0);
        chk("rst_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset    = 1'b0;
        sb.delete();
        mdl_send = 1'b0;
        mdl_last = 2'd3;
        mdl_ts   = '0;
        mdl_cnt  = 0;
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        last_hs_ts = '0;
        prev_hs_ts = '0;
        reset = 1'b1;
        rd_if.m_ready_i = 1'b0;
        drain_en = 1'b0;
        ch_en    = 4'b0000;
        ch_empty = 4'b1111;
        ch_data  = '0;
        @(negedge clk);
        do_reset();

        // Full round-robin, one beat per cycle.
        ch_empty = 4'b0000; ch_en = 4'b1111; drain_en = 1'b1; rd_if.m_ready_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cycle();
            chk("rr_seq", 64'(last_pop), 64'(4'b0001 << (i % 4)));
        end
        ch_empty = 4'b1111;
        cycle(); cycle();
        chk("rr_cnt8", 64'(beat_cnt), 64'd8);

        // Single W entry held under backpressure.
        ch_empty = 4'b1011; ch_data[2*DW +: DW] = 32'hDEADBEEF; rd_if.m_ready_i = 1'b0;
        cycle();
        ch_empty = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("w_hold_data", 64'(rd_if.m_data_o), 64'hDEADBEEF);
            chk("w_hold_ch", 64'(rd_if.m_ch_o), 64'd2);
        end
        rd_if.m_ready_i = 1'b1;
        cycle(); cycle();

        // Only AW and R enabled.
        ch_en = 4'b1010; ch_empty = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            rand_data();
            cycle();
            chk("en_mask", 64'(last_pop & 4'b0101), 64'd0);
        end
        ch_empty = 4'b1111;
        cycle(); cycle();
        ch_en = 4'b1111;

        // Global drain disable while a beat is stalled.
        ch_empty = 4'b0000; rd_if.m_ready_i = 1'b0; rand_data();
        cycle();
        drain_en = 1'b0;
        repeat (3) cycle();
        rd_if.m_ready_i = 1'b1;
        repeat (3) cycle();
        chk("drain_off_busy", 64'(busy), 64'd0);

        // Reset in SEND, then AR wins first.
        drain_en = 1'b1; rd_if.m_ready_i = 1'b0; rand_data();
        cycle(); cycle();
        ch_empty = 4'b0110;
        do_reset();
        rd_if.m_ready_i = 1'b1;
        cycle();
        chk("first_ar", 64'(last_pop), 64'd1);
        cycle();
        ch_empty = 4'b1111;
        cycle(); cycle();

        // Timestamp period and wrap.
        ch_empty = 4'b1110; rand_data();
        cycle();
        ch_empty = 4'b1111;
        repeat (15) cycle();
        ch_empty = 4'b1110; rand_data();
        cycle();
        ch_empty = 4'b1111;
        cycle(); cycle();
        chk("ts_period", 64'(last_hs_ts), 64'(prev_hs_ts));
        n = 0;
        while (mdl_ts != 4'd15 && n < 20) begin
            cycle();
            n++;
        end
        ch_empty = 4'b1110; rand_data();
        cycle();
        rand_data();
        cycle();
        ch_empty = 4'b1111;
        cycle(); cycle();
        chk("ts_wrap_a", 64'(prev_hs_ts), 64'd15);
        chk("ts_wrap_b", 64'(last_hs_ts), 64'd0);

        chk("sb_left", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
